// File: rtl/traffic_light_ctrl_gen.sv
// Two-direction intersection controller with a six-phase cycle, pedestrian green
// shortening, end-of-green flashing, flashing-yellow night mode and a BCD countdown.
module traffic_light_ctrl_gen #(
  parameter int CLK_DIV    = 50000000,
  parameter int T_GREEN_A  = 9,
  parameter int T_GREEN_B  = 9,
  parameter int T_YELLOW   = 3,
  parameter int T_ALLRED   = 1,
  parameter int MIN_GREEN  = 3,
  parameter int FLASH_LAST = 3
) (
  input  logic       clk_50MHz,
  input  logic       reset,
  input  logic       night_mode,
  input  logic       ped_req,
  output logic [5:0] light,
  output logic [2:0] phase,
  output logic [7:0] remaining,
  output logic       tick,
  output logic       ped_ack
);

  typedef enum logic [2:0] {
    PH_A_GREEN   = 3'd0,
    PH_A_YELLOW  = 3'd1,
    PH_ALLRED_AB = 3'd2,
    PH_B_GREEN   = 3'd3,
    PH_B_YELLOW  = 3'd4,
    PH_ALLRED_BA = 3'd5,
    PH_NIGHT     = 3'd6
  } phase_e;

  localparam int PW = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
  localparam logic [PW-1:0] PRE_MAX  = PW'(CLK_DIV - 1);
  localparam logic [PW-1:0] PRE_HALF = PW'(CLK_DIV / 2);

  function automatic logic [7:0] to_bcd(input int v);
    to_bcd = {4'(v / 10), 4'(v % 10)};
  endfunction

  localparam logic [7:0] BCD_GA    = to_bcd(T_GREEN_A);
  localparam logic [7:0] BCD_GB    = to_bcd(T_GREEN_B);
  localparam logic [7:0] BCD_YEL   = to_bcd(T_YELLOW);
  localparam logic [7:0] BCD_AR    = to_bcd(T_ALLRED);
  localparam logic [7:0] BCD_MIN   = to_bcd(MIN_GREEN);
  localparam logic [7:0] BCD_FLASH = to_bcd(FLASH_LAST);

  // BCD decrement that never goes below 01.
  function automatic logic [7:0] bcd_dec(input logic [7:0] v);
    if (v <= 8'h01)
      bcd_dec = 8'h01;
    else if (v[3:0] == 4'd0)
      bcd_dec = {v[7:4] - 4'd1, 4'd9};
    else
      bcd_dec = {v[7:4], v[3:0] - 4'd1};
  endfunction

  function automatic phase_e next_phase(input phase_e p);
    case (p)
      PH_A_GREEN:   next_phase = PH_A_YELLOW;
      PH_A_YELLOW:  next_phase = PH_ALLRED_AB;
      PH_ALLRED_AB: next_phase = PH_B_GREEN;
      PH_B_GREEN:   next_phase = PH_B_YELLOW;
      PH_B_YELLOW:  next_phase = PH_ALLRED_BA;
      default:      next_phase = PH_A_GREEN;
    endcase
  endfunction

  function automatic logic [7:0] dur_bcd(input phase_e p);
    case (p)
      PH_A_GREEN:                 dur_bcd = BCD_GA;
      PH_B_GREEN:                 dur_bcd = BCD_GB;
      PH_A_YELLOW, PH_B_YELLOW:   dur_bcd = BCD_YEL;
      PH_ALLRED_AB, PH_ALLRED_BA: dur_bcd = BCD_AR;
      default:                    dur_bcd = 8'h00;
    endcase
  endfunction

  // Lamp word {A_red, A_yel, A_grn, B_red, B_yel, B_grn}.
  function automatic logic [5:0] lamps(input phase_e p, input logic [7:0] rem, input logic blink);
    logic flash_off;
    flash_off = (rem <= BCD_FLASH) && blink;
    case (p)
      PH_A_GREEN:  lamps = {2'b00, ~flash_off, 3'b100};
      PH_A_YELLOW: lamps = 6'b010100;
      PH_B_GREEN:  lamps = {3'b100, 2'b00, ~flash_off};
      PH_B_YELLOW: lamps = 6'b100010;
      PH_NIGHT:    lamps = {1'b0, ~blink, 2'b00, ~blink, 1'b0};
      default:     lamps = 6'b100100;
    endcase
  endfunction

  logic [PW-1:0] presc_q, presc_d;
  phase_e        phase_q, phase_d;
  logic [7:0]    rem_q, rem_d;
  logic          tick_q, tick_d;
  logic          ack_q, ack_d;
  logic          pend_q, pend_d;
  logic [5:0]    light_q, light_d;
  logic          tick_now;
  logic          shorten;

  always_comb begin
    presc_d  = (presc_q == PRE_MAX) ? '0 : presc_q + PW'(1);
    tick_now = (presc_q == PRE_MAX);
    tick_d   = (presc_d == PRE_MAX);
    phase_d  = phase_q;
    rem_d    = rem_q;
    ack_d    = 1'b0;
    pend_d   = pend_q | ped_req;
    shorten  = ((phase_q == PH_A_GREEN) || (phase_q == PH_B_GREEN)) &&
               (pend_q | ped_req) && (rem_q > BCD_MIN);

    case (phase_q)
      PH_NIGHT: begin
        if (tick_now && !night_mode) begin
          phase_d = PH_ALLRED_BA;
          rem_d   = BCD_AR;
        end
      end
      PH_A_GREEN, PH_A_YELLOW, PH_ALLRED_AB,
      PH_B_GREEN, PH_B_YELLOW, PH_ALLRED_BA: begin
        if (tick_now && night_mode) begin
          phase_d = PH_NIGHT;
          rem_d   = 8'h00;
          pend_d  = ped_req;
        end else if (shorten) begin
          // A shortening load also swallows a coincident tick decrement.
          rem_d = BCD_MIN;
        end else if (tick_now) begin
          if (rem_q <= 8'h01) begin
            phase_d = next_phase(phase_q);
            rem_d   = dur_bcd(next_phase(phase_q));
          end else begin
            rem_d = bcd_dec(rem_q);
          end
        end
      end
      default: begin
        phase_d = PH_A_GREEN;
        rem_d   = BCD_GA;
      end
    endcase

    // Serve a request already pending when an all-red clearance begins.
    if (((phase_d == PH_ALLRED_AB) || (phase_d == PH_ALLRED_BA)) &&
        (phase_d != phase_q) && pend_q) begin
      ack_d  = 1'b1;
      pend_d = ped_req;
    end

    light_d = lamps(phase_d, rem_d, presc_d >= PRE_HALF);
  end

  always_ff @(posedge clk_50MHz) begin
    if (reset) begin
      presc_q <= '0;
      phase_q <= PH_A_GREEN;
      rem_q   <= BCD_GA;
      tick_q  <= 1'b0;
      ack_q   <= 1'b0;
      pend_q  <= 1'b0;
      light_q <= 6'b001100;
    end else begin
      presc_q <= presc_d;
      phase_q <= phase_d;
      rem_q   <= rem_d;
      tick_q  <= tick_d;
      ack_q   <= ack_d;
      pend_q  <= pend_d;
      light_q <= light_d;
    end
  end

  assign light     = light_q;
  assign phase     = phase_q;
  assign remaining = rem_q;
  assign tick      = tick_q;
  assign ped_ack   = ack_q;

endmodule

// File: tb/tb_traffic_light_ctrl_gen.sv
// Directed bench for traffic_light_ctrl_gen (CLK_DIV=4): expectations are queued per
// cycle by the stimulus and compared by an independent negedge monitor.
module tb_traffic_light_ctrl_gen;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset, night_mode, ped_req;
  logic [5:0] light;
  logic [2:0] phase;
  logic [7:0] remaining;
  logic       tick, ped_ack;

  logic       reset12, night12, ped12;
  logic [5:0] light12;
  logic [2:0] phase12;
  logic [7:0] remaining12;
  logic       tick12, ped_ack12;

  traffic_light_ctrl_gen #(.CLK_DIV(4)) dut (
    .clk_50MHz(clk), .reset(reset), .night_mode(night_mode), .ped_req(ped_req),
    .light(light), .phase(phase), .remaining(remaining), .tick(tick), .ped_ack(ped_ack)
  );

  traffic_light_ctrl_gen #(.CLK_DIV(4), .T_GREEN_A(12)) dut12 (
    .clk_50MHz(clk), .reset(reset12), .night_mode(night12), .ped_req(ped12),
    .light(light12), .phase(phase12), .remaining(remaining12), .tick(tick12),
    .ped_ack(ped_ack12)
  );

  typedef struct {
    int    cyc;
    int    sel;
    string nm;
    int    ph;
    int    rm;
    int    lt;
    int    tk;
    int    ak;
  } exp_t;

  exp_t sb[$];
  exp_t me;
  int   gcyc   = 0;
  int   errors = 0;
  int   checks = 0;
  int   c      = 0;

  always @(posedge clk) gcyc <= gcyc + 1;

  task automatic chk(input string nm, input string f, input int act, input int expv);
    if (expv >= 0) begin
      checks++;
      if (act != expv) begin
        errors++;
        $display("FAIL %s.%s: got %0h expected %0h (cycle %0d)", nm, f, act, expv, gcyc);
      end
    end
  endtask

  // Monitor: compares every expectation queued for the current cycle.
  always @(negedge clk) begin
    while (sb.size() > 0 && sb[0].cyc <= gcyc) begin
      me = sb.pop_front();
      if (me.cyc < gcyc) begin
        checks++;
        errors++;
        $display("FAIL %s: expectation for cycle %0d not compared until cycle %0d", me.nm, me.cyc, gcyc);
      end else if (me.sel == 0) begin
        chk(me.nm, "phase", int'(phase), me.ph);
        chk(me.nm, "remaining", int'(remaining), me.rm);
        chk(me.nm, "light", int'(light), me.lt);
        chk(me.nm, "tick", int'(tick), me.tk);
        chk(me.nm, "ped_ack", int'(ped_ack), me.ak);
      end else begin
        chk(me.nm, "phase", int'(phase12), me.ph);
        chk(me.nm, "remaining", int'(remaining12), me.rm);
        chk(me.nm, "light", int'(light12), me.lt);
        chk(me.nm, "tick", int'(tick12), me.tk);
        chk(me.nm, "ped_ack", int'(ped_ack12), me.ak);
      end
    end
  end

  task automatic ex(input int sel, input string nm, input int ph, input int rm,
                    input int lt, input int tk, input int ak);
    exp_t e;
    e.cyc = gcyc; e.sel = sel; e.nm = nm;
    e.ph = ph; e.rm = rm; e.lt = lt; e.tk = tk; e.ak = ak;
    sb.push_back(e);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    c++;
  endtask

  task automatic run_to(input int t);
    while (c < t) step();
  endtask

  function automatic int bcd(input int v);
    return (v / 10) * 16 + (v % 10);
  endfunction

  task automatic do_reset(input int sel);
    if (sel == 0) reset = 1'b1; else reset12 = 1'b1;
    step();
    c = 0;
    ex(sel, "reset", 0, (sel == 0) ? 'h09 : 'h12, 'b001100, 0, 0);
    if (sel == 0) reset = 1'b0; else reset12 = 1'b0;
  endtask

  int dur[6]    = '{9, 3, 1, 9, 3, 1};
  int lt_tab[6] = '{'b001100, 'b010100, 'b100100, 'b100001, 'b100010, 'b100100};

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    reset = 1'b1; night_mode = 1'b0; ped_req = 1'b0;
    reset12 = 1'b1; night12 = 1'b0; ped12 = 1'b0;

    // Full sequence over 60 ticks.
    do_reset(0);
    for (int k = 1; k <= 240; k++) begin
      step();
      if (k % 4 == 0) begin
        int s, ph;
        s = (k / 4) % 26;
        ph = 0;
        while (s >= dur[ph]) begin
          s -= dur[ph];
          ph++;
        end
        ex(0, "seq", ph, bcd(dur[ph] - s), lt_tab[ph], 0, 0);
      end else if (k % 4 == 3) begin
        ex(0, "seq_tick", -1, -1, -1, 1, 0);
      end
    end

    // Pedestrian shortening in A_GREEN.
    do_reset(0);
    run_to(8);  ex(0, "pa_pre", 0, 'h07, -1, -1, 0);
    ped_req = 1'b1; step(); ped_req = 1'b0;
    ex(0, "pa_short", 0, 'h03, 'b001100, 0, 0);
    step();     ex(0, "pa_flash", 0, 'h03, 'b000100, -1, 0);
    run_to(19); ex(0, "pa_last", 0, 'h01, -1, 1, 0);
    run_to(20); ex(0, "pa_yel", 1, 'h03, 'b010100, 0, 0);
    run_to(31); ex(0, "pa_noack", 1, 'h01, -1, 1, 0);
    run_to(32); ex(0, "pa_ack", 2, 'h01, 'b100100, 0, 1);
    run_to(33); ex(0, "pa_ack_end", 2, 'h01, -1, -1, 0);
    run_to(36); ex(0, "bg_start", 3, 'h09, 'b100001, 0, 0);

    // Request below MIN_GREEN in B_GREEN: no shortening, ack at ALLRED_BA.
    run_to(64);
    ped_req = 1'b1; step(); ped_req = 1'b0;
    ex(0, "pb_keep", 3, 'h02, 'b100001, -1, 0);
    step();     ex(0, "pb_flash", 3, 'h02, 'b100000, -1, 0);
    run_to(72); ex(0, "pb_yel", 4, 'h03, 'b100010, 0, 0);
    run_to(84); ex(0, "pb_ack", 5, 'h01, 'b100100, 0, 1);
    run_to(85); ex(0, "pb_ack_end", 5, 'h01, -1, -1, 0);
    run_to(88); ex(0, "ag_again", 0, 'h09, 'b001100, 0, 0);

    // End-of-green flashing window.
    run_to(107);
    for (int k = 108; k <= 123; k++) begin
      int rv;
      step();
      rv = 4 - (k - 108) / 4;
      ex(0, "blink", 0, rv, (rv <= 3 && (k % 4) >= 2) ? 'b000100 : 'b001100, -1, 0);
    end
    run_to(124); ex(0, "ay2", 1, 'h03, 'b010100, 0, 0);

    // Night mode entered mid B_GREEN with a request pending.
    run_to(140); ex(0, "bg2", 3, 'h09, 'b100001, 0, 0);
    run_to(144);
    ped_req = 1'b1; step(); ped_req = 1'b0;
    ex(0, "bg2_short", 3, 'h03, -1, -1, 0);
    run_to(148); night_mode = 1'b1; ex(0, "pre_night", 3, 'h02, -1, 0, 0);
    run_to(151); ex(0, "night_wait", 3, 'h02, -1, 1, 0);
    for (int k = 152; k <= 159; k++) begin
      step();
      ex(0, "night", 6, 'h00, ((k % 4) < 2) ? 'b010010 : 'b000000, -1, 0);
    end
    run_to(160); night_mode = 1'b0; ex(0, "night_hold", 6, 'h00, 'b010010, 0, 0);
    run_to(164); ex(0, "resume", 5, 'h01, 'b100100, 0, 0);
    run_to(168); ex(0, "resume_a", 0, 'h09, 'b001100, 0, 0);

    // Shortening load coinciding with a tick.
    run_to(171);
    ped_req = 1'b1; step(); ped_req = 1'b0;
    ex(0, "load_wins", 0, 'h03, -1, 0, 0);
    run_to(184); ex(0, "lw_yel", 1, 'h03, -1, 0, 0);
    run_to(196); ex(0, "lw_ack", 2, 'h01, -1, 0, 1);

    // Reset mid-operation with night mode and a request active.
    run_to(200);
    night_mode = 1'b1; ped_req = 1'b1;
    do_reset(0);
    night_mode = 1'b0; ped_req = 1'b0;
    run_to(48); ex(0, "rst_noack", 2, 'h01, 'b100100, 0, 0);

    // Two-digit green with BCD borrow, and reset at 0x10.
    do_reset(1);
    run_to(8);  ex(1, "g12_10", 0, 'h10, -1, 0, 0);
    step();
    reset12 = 1'b1; step();
    ex(1, "g12_rst", 0, 'h12, 'b001100, 0, 0);
    reset12 = 1'b0; c = 0;
    run_to(4);  ex(1, "g12_11", 0, 'h11, -1, 0, 0);
    run_to(8);  ex(1, "g12_10b", 0, 'h10, -1, 0, 0);
    run_to(12); ex(1, "g12_09", 0, 'h09, 'b001100, 0, 0);

    step();
    step();
    if (sb.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL scoreboard: %0d expectations never compared", sb.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/traffic_light_ctrl_gen.md
Name: traffic_light_ctrl_gen

Overview:
- Parametrised two-direction intersection controller (direction A / direction B) with a six-phase cycle and per-phase programmable durations.
- Also provides: pedestrian-request green shortening, end-of-green flashing, night (flashing-yellow) mode and a BCD countdown for the seven-segment display driver.
- Runs entirely on clk_50MHz using an internal 1 s tick enable; no derived clocks.

Parameters:
- CLK_DIV, 50000000: clk_50MHz cycles per 1 s tick; must be even and ≥4.
- T_GREEN_A, 9: A green duration in seconds (1..99).
- T_GREEN_B, 9: B green duration in seconds (1..99).
- T_YELLOW, 3: yellow duration in seconds, both directions (1..99).
- T_ALLRED, 1: all-red clearance duration in seconds (1..99).
- MIN_GREEN, 3: remaining seconds a green is cut to on pedestrian request (1..99).
- FLASH_LAST, 3: green flashes while remaining ≤ FLASH_LAST (0 disables).

Ports:
- clk_50MHz  in  1  system clock
- reset  in  1  synchronous, active-high
- night_mode  in  1  level; 1 requests flashing-yellow mode
- ped_req  in  1  level/pulse pedestrian button, already synchronised
- light  out  6  {A_red, A_yel, A_grn, B_red, B_yel, B_grn}, 1 = lamp on
- phase  out  3  0 A_GREEN, 1 A_YELLOW, 2 ALLRED_AB, 3 B_GREEN, 4 B_YELLOW, 5 ALLRED_BA, 6 NIGHT
- remaining  out  8  BCD seconds left in phase, [7:4] tens, [3:0] units
- tick  out  1  one-cycle pulse each second
- ped_ack  out  1  one-cycle pulse when a pending request is served

Behaviour:
- Reset state (all outputs registered):
  - phase=A_GREEN, remaining=BCD(T_GREEN_A), prescaler=0, ped_pending=0.
  - tick=0, ped_ack=0, light=6'b001100.
- Prescaler and tick:
  - Prescaler counts 0..CLK_DIV-1 and wraps.
  - tick=1 in the cycle in which the prescaler==CLK_DIV-1.
  - blink=1 while prescaler ≥ CLK_DIV/2.
- Phase sequence: A_GREEN → A_YELLOW → ALLRED_AB → B_GREEN → B_YELLOW → ALLRED_BA → A_GREEN.
- Phase timing:
  - On tick with remaining==01, advance to the next phase and load that phase's duration in BCD.
  - On any other tick, remaining decrements in BCD: units 0 → 9 with tens borrow; never below 01.
  - Each phase therefore lasts exactly its duration in ticks.
- Lamps:
  - The non-green, non-yellow direction shows red.
  - Both directions show red in ALLRED_AB/ALLRED_BA.
  - The active green lamp is forced off when phase is a GREEN, remaining ≤ FLASH_LAST, and blink=1.
- Pedestrian request:
  - ped_req=1 on any cycle sets ped_pending.
  - In A_GREEN/B_GREEN with ped_pending=1 and remaining > MIN_GREEN, remaining is loaded with BCD(MIN_GREEN) on the next cycle.
  - If that cycle is also a tick, the load wins and the decrement is dropped.
  - On entry to ALLRED_AB or ALLRED_BA with ped_pending=1: ped_ack pulses for one cycle and ped_pending clears.
  - A ped_req arriving in that same cycle keeps ped_pending set.
- Night mode:
  - Evaluated only on tick.
  - night_mode=1 from any phase → NIGHT; remaining=00; ped_pending cleared without ped_ack.
  - In NIGHT, light={0, ~blink, 0, 0, ~blink, 0}.
  - On the first tick with night_mode=0 → ALLRED_BA with remaining=BCD(T_ALLRED); normal sequence resumes from there.
- Next-state decode:
  - Combinational and fully specified.
  - Illegal phase codes (7) → A_GREEN with BCD(T_GREEN_A) on the next cycle.
- Reset mid-operation: restores the reset state in the following cycle, regardless of phase, night mode or pending request.
- Outputs change only on clk_50MHz rising edges; no combinational input-to-output paths.

Test Plan (CLK_DIV=4, defaults otherwise):
- Reset then run 60 ticks:
  - phase follows 0,1,2,3,4,5,0 with 9,3,1,9,3,1 ticks each.
  - remaining goes 09..01 in A_GREEN.
  - light=001100 / 010100 / 100100 / 100001 / 100010 / 100100 per phase.
- A_GREEN with remaining=07, one-cycle ped_req:
  - remaining=03 next cycle.
  - After 3 ticks phase=A_YELLOW.
  - ped_ack pulses once on entry to ALLRED_AB.
- ped_req while remaining=02 in B_GREEN: remaining unchanged; ped_ack on entry to ALLRED_BA.
- A_GREEN at remaining 03..01: light[3] toggles with blink (off when prescaler ∈{2,3}); at remaining 04, no toggling.
- night_mode=1 mid B_GREEN:
  - Next tick: phase=6, remaining=00, light alternates 010010/000000 each half tick.
  - Drop night_mode: next tick phase=5, remaining=01, then A_GREEN with 09.
- T_GREEN_A=12 build, run A_GREEN: remaining 12,11,10,09 (BCD borrow 0x10 → 0x09); reset asserted at 0x10 gives phase=0, remaining=0x12 the next cycle.
